// File: rtl/uart_rx_core.sv
// uart_rx_core -- UART receiver with OVERSAMPLE-times oversampling.
//
// Samples the asynchronous rx line through a two-flop synchronizer and
// checks the start and stop bits. Each received byte goes into a
// valid/ready holding register.
//
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, the
// receiver expects one even-parity bit after the data bits and drives
// the extra port parity_err.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   rx           serial line, idle high, asynchronous to clk
//   rx_ready     consumer accepts rx_data while rx_valid=1
//   rx_data      received byte
//   rx_valid     rx_data holds an unconsumed byte
//   rx_busy      high whenever a frame is being received or a break is pending
//   frame_err    one-cycle pulse when the stop bit is sampled low
//   overrun_err  one-cycle pulse when a new byte overwrites an unconsumed one
//   parity_err   (UART_RX_PARITY_EN only) one-cycle pulse, aligned with the
//                rx_valid rise, when the parity check fails
//
// State table:
//   IDLE      | waiting for a falling edge on rx_s
//   START     | confirming the start bit at its centre
//   DATA      | sampling DATA_BITS payload bits at their centres
//   PARITY    | sampling the parity bit (UART_RX_PARITY_EN only)
//   STOP      | sampling the stop bit; deliver the byte or flag a frame error
//   WAIT_HIGH | line held low after a bad stop bit; wait for it to return high
module uart_rx_core #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
  localparam logic [SW-1:0] MID   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SLAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_s;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [SW-1:0]        scnt, scnt_n;
  logic [BW-1:0]        bidx, bidx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n, ferr_n, ovr_n, load;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_n, perr_n;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {rx_s, rx_meta} <= 2'b11;
    else     {rx_s, rx_meta} <= {rx_meta, rx};
  end

  // Free-running oversample tick. It is not realigned on a start edge, so
  // start detection has up to one tick of jitter.
  assign tick = (div_cnt == DLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      scnt        <= '0;
      bidx        <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      scnt        <= scnt_n;
      bidx        <= bidx_n;
      shreg       <= shreg_n;
      rx_data     <= data_n;
      rx_valid    <= valid_n;
      frame_err   <= ferr_n;
      overrun_err <= ovr_n;
`ifdef UART_RX_PARITY_EN
      par_bit     <= par_n;
      parity_err  <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    bidx_n  = bidx;
    shreg_n = shreg;
    data_n  = rx_data;
    valid_n = rx_valid & ~rx_ready;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
    load    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_bit;
    perr_n  = 1'b0;
`endif

    case (state)
      IDLE: begin
        scnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (tick) begin
          if (scnt == MID) begin
            // Re-zeroing here puts every later sample at a bit centre.
            scnt_n  = '0;
            bidx_n  = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (scnt == SLAST) begin
            scnt_n  = '0;
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            bidx_n  = bidx + 1'b1;
            if (bidx == BLAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (scnt == SLAST) begin
            scnt_n  = '0;
            par_n   = rx_s;
            state_n = STOP;
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (scnt == SLAST) begin
            scnt_n = '0;
            // Return at the stop-bit centre so the next start edge is not missed.
            if (rx_s) begin
              load    = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = WAIT_HIGH;
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not be read as repeated zero bytes.
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      data_n  = shreg;
      valid_n = 1'b1;
      ovr_n   = rx_valid & ~rx_ready;
`ifdef UART_RX_PARITY_EN
      perr_n  = (^shreg) ^ par_bit;
`endif
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD_T = 115200;
  localparam int OS     = 16;
  localparam int DIV_T  = CLK_HZ / (BAUD_T * OS);
  localparam int BIT_T  = DIV_T * OS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int errors = 0;
  int checks = 0;
  int cyc;
  int ferr_seen = 0, ovr_seen = 0, perr_seen = 0;

  typedef struct {
    int         at;
    logic [7:0] data;
    logic       ok;
    logic       perr;
  } ev_t;
  ev_t evq[$];

  logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_data = 8'h00;
`ifdef UART_RX_PARITY_EN
  logic       m_perr = 1'b0;
`endif

  uart_rx_core #(
    .CLK_FREQ(CLK_HZ), .BAUD(BAUD_T), .OVERSAMPLE(OS), .DATA_BITS(8)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .frame_err(frame_err), .overrun_err(overrun_err)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle in which rx_valid / frame_err become visible for a frame whose
  // start edge is driven in cycle a: 2-flop sync plus one cycle to leave
  // IDLE, then the 8th tick (start centre), 16 ticks per later bit, and
  // one register cycle after the stop-sample tick.
  function automatic int predict_done(input int a, input int par);
    int c;
    c = a + 3;
    while ((c % DIV_T) != DIV_T - 1) c++;
    return c + 7 * DIV_T + (9 + par) * BIT_T + 1;
  endfunction

  // nbits=0 sends the whole frame; otherwise only the first nbits line bits.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits,
                            input logic use_par, input logic pbit);
    logic [10:0] bits;
    int n;
    @(posedge clk); #1;
    n = use_par ? 11 : 10;
    if (use_par) bits = {stop, pbit, d, 1'b0};
    else         bits = {1'b0, stop, d, 1'b0};
    if (nbits == 0)
      evq.push_back('{predict_done(cyc, use_par ? 1 : 0), d, stop, ((^d) ^ pbit) & use_par});
    for (int i = 0; i < n; i++) begin
      if (nbits != 0 && i == nbits) break;
      rx = bits[i];
      repeat (BIT_T) @(posedge clk);
      #1;
    end
  endtask

  task automatic consume();
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  // Per-cycle comparison against the frame-level model.
  initial begin
    ev_t  ev;
    logic nv;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0;
`ifdef UART_RX_PARITY_EN
        m_perr = 1'b0;
        chk("reset_parity_err", {31'd0, parity_err}, 0);
`endif
        evq.delete();
        chk("reset_outputs", {20'd0, overrun_err, frame_err, rx_busy, rx_valid, rx_data}, 0);
      end else begin
        chk("outputs", {21'd0, overrun_err, frame_err, rx_valid, rx_data},
                       {21'd0, m_ovr, m_ferr, m_valid, m_data});
`ifdef UART_RX_PARITY_EN
        chk("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
        if (parity_err) perr_seen++;
        m_perr = 1'b0;
`endif
        if (frame_err) ferr_seen++;
        if (overrun_err) ovr_seen++;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        nv = m_valid & ~rx_ready;
        if (evq.size() > 0 && evq[0].at == cyc + 1) begin
          ev = evq.pop_front();
          if (ev.ok) begin
            m_ovr  = m_valid & ~rx_ready;
            m_data = ev.data;
            nv     = 1'b1;
`ifdef UART_RX_PARITY_EN
            m_perr = ev.perr;
`endif
          end else begin
            m_ferr = 1'b1;
          end
        end
        m_valid = nv;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int a, d, base;
    #23 rst = 1'b0;

    // 1: single byte held with rx_ready low, then one-cycle accept
    send_frame(8'h56, 1'b1, 0, 1'b0, 1'b0);
    repeat (20) @(posedge clk); #1;
    chk("t1_data", rx_data, 8'h56);
    chk("t1_valid_held", rx_valid, 1);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    chk("t1_valid_cleared", rx_valid, 0);
    rx_ready = 1'b0;
    chk("t1_no_frame_err", ferr_seen, 0);

    // 2: 4-tick glitch is a false start
    @(posedge clk); #1;
    a = cyc;
    rx = 1'b0;
    repeat (4 * DIV_T) @(posedge clk); #1;
    rx = 1'b1;
    chk("t2_busy_during_glitch", rx_busy, 1);
    repeat (BIT_T - 4 * DIV_T) @(posedge clk); #1;
    chk("t2_busy_idle_in_one_bit", rx_busy, 0);
    chk("t2_no_valid", rx_valid, 0);
    chk("t2_no_frame_err", ferr_seen, 0);

    // 3: bad stop bit followed by a break, then a good frame
    send_frame(8'h93, 1'b0, 0, 1'b0, 1'b0);
    repeat (2 * BIT_T) @(posedge clk); #1;
    chk("t3_busy_wait_high", rx_busy, 1);
    chk("t3_one_frame_err", ferr_seen, 1);
    chk("t3_no_valid", rx_valid, 0);
    rx = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("t3_idle_after_rise", rx_busy, 0);
    send_frame(8'h56, 1'b1, 0, 1'b0, 1'b0);
    repeat (20) @(posedge clk); #1;
    chk("t3_next_data", rx_data, 8'h56);
    chk("t3_next_valid", rx_valid, 1);
    chk("t3_frame_err_total", ferr_seen, 1);
    consume();

    // 4: overrun on back-to-back frames, then accept in the completion cycle
    base = ovr_seen;
    send_frame(8'h56, 1'b1, 0, 1'b0, 1'b0);
    send_frame(8'h93, 1'b1, 0, 1'b0, 1'b0);
    repeat (20) @(posedge clk); #1;
    chk("t4_one_overrun", ovr_seen - base, 1);
    chk("t4_data", rx_data, 8'h93);
    chk("t4_valid", rx_valid, 1);
    fork
      send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
      begin
        @(posedge clk); #1;
        d = predict_done(cyc, 0);
        while (cyc != d - 1) begin
          @(posedge clk); #1;
        end
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
      end
    join
    repeat (20) @(posedge clk); #1;
    chk("t4_no_overrun_on_accept", ovr_seen - base, 1);
    chk("t4_accept_data", rx_data, 8'hA5);
    chk("t4_accept_valid", rx_valid, 1);

    // 5: async reset mid-frame with a byte still pending
    send_frame(8'h93, 1'b1, 4, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t5_reset_immediate", {20'd0, overrun_err, frame_err, rx_busy, rx_valid, rx_data}, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    send_frame(8'h93, 1'b1, 0, 1'b0, 1'b0);
    repeat (20) @(posedge clk); #1;
    chk("t5_data_after_reset", rx_data, 8'h93);
    chk("t5_valid_after_reset", rx_valid, 1);

`ifdef UART_RX_PARITY_EN
    // 6: even parity, good and bad parity bit
    consume();
    base = perr_seen;
    send_frame(8'h56, 1'b1, 0, 1'b1, 1'b0);
    repeat (20) @(posedge clk); #1;
    chk("t6_good_parity_valid", rx_valid, 1);
    chk("t6_good_parity_no_err", perr_seen - base, 0);
    consume();
    send_frame(8'h56, 1'b1, 0, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
    chk("t6_bad_parity_valid", rx_valid, 1);
    chk("t6_bad_parity_data", rx_data, 8'h56);
    chk("t6_bad_parity_err", perr_seen - base, 1);
`endif

    repeat (5) @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Standalone UART receiver with 16x oversampling. It samples the asynchronous `rx` line, checks start and stop framing, and delivers each byte through a valid/ready holding register. It sits between the board RX pin and consumers such as the command decoder, segment display or loopback TX path. It is the receiving end for frames produced by the existing transmit path and by bench serial drivers.

Parameters:
- CLK_FREQ, 100_000_000: clk frequency in Hz.
- BAUD, 9600: line bit rate.
- OVERSAMPLE, 16: ticks per bit. Must be even and ≥ 8.
- DATA_BITS, 8: payload bits per frame, sent LSB first.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- rx, input, 1: serial line, idle high, asynchronous to clk.
- rx_ready, input, 1: consumer accepts rx_data in any cycle where rx_valid=1.
- rx_data, output, DATA_BITS: received byte.
- rx_valid, output, 1: rx_data holds an unconsumed byte.
- rx_busy, output, 1: high whenever the FSM is not IDLE.
- frame_err, output, 1: one-cycle pulse when the stop bit is sampled low.
- overrun_err, output, 1: one-cycle pulse when a new byte overwrites an unconsumed one.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun_err=0.
  - Both synchronizer flops=1, FSM=IDLE, all counters=0.
- Synchronizer: two flops, rx → rx_s. Each edge of rx appears on rx_s after 2 clk.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation (100 MHz at 115200 gives 54).
  - Free-running counter 0..DIV-1. tick=1 in the cycle the counter equals DIV-1, then the counter wraps to 0.
  - The counter is not resynchronized on a start edge. Resulting jitter is ≤1 tick, which is acceptable.
- Sample counter `scnt` (0..OVERSAMPLE-1) advances on tick only. MID = OVERSAMPLE/2-1.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s=0 → START, scnt=0.
  - START: on tick with scnt=MID:
    - rx_s=0 → DATA, scnt=0, bit index=0.
    - rx_s=1 → false start, return to IDLE with no output.
  - DATA: on tick with scnt=OVERSAMPLE-1:
    - scnt wraps to 0 and rx_s is shifted in at the MSB side (shift right), so the first bit lands at bit 0.
    - After DATA_BITS samples → STOP.
    - The sample point is the bit centre, because START re-zeroed scnt at its mid-point.
  - STOP: on tick with scnt=OVERSAMPLE-1, sample rx_s:
    - 1 → load rx_data from the shift register, set rx_valid=1, go to IDLE. The early return at bit centre gives half a bit of resync margin.
    - 0 → frame_err pulse for 1 cycle, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then IDLE. This prevents a break condition from being read as repeated 0x00 frames.
- Output handshake:
  - rx_valid clears the cycle after any cycle with rx_valid & rx_ready.
  - rx_data is stable while rx_valid=1, unless an overrun occurs.
  - New byte while rx_valid=1 and rx_ready=0: rx_data is overwritten, rx_valid stays 1, overrun_err pulses for 1 cycle.
  - New byte in the same cycle as rx_valid & rx_ready: load the new byte, rx_valid stays 1, no overrun.
- Latency: rx_valid rises 1 clk after the stop-sample tick.
- Reset mid-frame: asynchronous return to the reset values. The partial byte is lost, and rx_valid is cleared even if unconsumed.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - An extra state PARITY sits between DATA and STOP and samples one even-parity bit.
  - A new port parity_err (output, 1, reset 0) pulses for 1 cycle in the cycle rx_valid would rise, when the XOR of the data bits and the parity bit is 1.
  - On parity error the byte is still delivered with rx_valid=1. The consumer decides what to do with it.
- Undefined:
  - 8N1 framing only. No PARITY state and no parity_err port.

Test Plan:
1. BAUD=115200 (DIV=54), rx_ready=0, send frame 0x56 (line bits 0,1,1,0,1,0,1,0 after the start bit) → rx_data=0x56 and rx_valid=1 held. Pulse rx_ready for 1 cycle → rx_valid=0 next cycle. frame_err never asserts.
2. Drive rx low for 4 ticks then high (glitch) → FSM returns to IDLE, rx_busy back to 0 within one bit time, no rx_valid, no frame_err.
3. Send 0x93 with the stop bit driven 0, hold rx low for 3 bit times, then high → one frame_err pulse, rx_valid stays 0, FSM stays in WAIT_HIGH until rx rises. A following 0x56 frame is received correctly.
4. Send 0x56 then 0x93 back-to-back with rx_ready=0 → one overrun_err pulse at the second stop sample, rx_data=0x93, rx_valid=1. Repeat with rx_ready asserted in the exact completion cycle → no overrun_err.
5. Assert rst asynchronously (mid-clock) after the 3rd data bit of a frame → all outputs take their reset values immediately. After release, a 0x93 frame yields rx_data=0x93.
6. UART_RX_PARITY_EN defined:
   - 0x56 with parity bit 0 → rx_valid=1, parity_err=0.
   - 0x56 with parity bit 1 → rx_valid=1 and a 1-cycle parity_err pulse.
